// File: rtl/fifo_umbrales.sv
// ============================================================================
// Module   : fifo_umbrales
// Purpose  : Single-clock lane FIFO with programmable almost-full/almost-empty
//            thresholds and a sticky overflow/underflow error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_umbrales #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 3,
  parameter int UMBRALES_L_H = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [UMBRALES_L_H-1:0] umbral_LH,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic                    error
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int HALF_W = UMBRALES_L_H / 2;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int CMP_W  = (HALF_W > CNT_W) ? HALF_W : CNT_W;

  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic              push_acc;
  logic              pop_acc;
  logic              overflow;
  logic              underflow;
  logic [HALF_W-1:0] umbral_h;
  logic [HALF_W-1:0] umbral_l;
  logic [CMP_W-1:0]  count_ext;
  logic [CMP_W-1:0]  umbral_h_ext;
  logic [CMP_W-1:0]  umbral_l_ext;

  // A push into a full FIFO is still accepted when a pop frees the slot.
  assign push_acc  = push && (!full || pop);
  assign pop_acc   = pop && !empty;
  assign overflow  = push && full && !pop;
  assign underflow = pop && empty;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  assign umbral_h     = umbral_LH[UMBRALES_L_H-1 -: HALF_W];
  assign umbral_l     = umbral_LH[HALF_W-1:0];
  assign count_ext    = CMP_W'(count);
  assign umbral_h_ext = CMP_W'(umbral_h);
  assign umbral_l_ext = CMP_W'(umbral_l);

  // Threshold flags follow the live threshold word, not a registered copy.
  assign almost_full  = (count_ext >= umbral_h_ext);
  assign almost_empty = (count_ext <= umbral_l_ext);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_acc && !reset) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop_acc;
      if (pop_acc) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if (overflow || underflow) begin
      error <= 1'b1;
    end
  end

endmodule

`default_nettype wire
